// File: rtl/collision_scheduler.sv
// Frame-level collision sequencer: shares one terrain column read port among NUM_OBJ objects.
// Optional wall probes (left/right columns, impact flag) enabled by `COLSCHED_WALL_PROBE_EN.
module collision_scheduler #(
  parameter int NUM_OBJ  = 4,
  parameter int COL_W    = 512,
  parameter int SCREEN_W = 640,
  parameter int RD_LAT   = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  frame_start,
  input  logic [NUM_OBJ*10-1:0] obj_x,
  input  logic [NUM_OBJ*10-1:0] obj_y,
  input  logic [NUM_OBJ*10-1:0] obj_r,
  input  logic [NUM_OBJ-1:0]    obj_active,
  output logic                  col_rd,
  output logic [9:0]            col_addr,
  input  logic [COL_W-1:0]      col_data,
  output logic [NUM_OBJ-1:0]    landed,
  output logic [NUM_OBJ-1:0]    bounce,
  output logic [NUM_OBJ-1:0]    impact,
  output logic                  busy,
  output logic                  done
);

  localparam int IdxW = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
  localparam int BitW = (COL_W > 1) ? $clog2(COL_W) : 1;
  localparam logic [10:0] ColLim = 11'(COL_W);
  localparam logic [10:0] ScrLim = 11'(SCREEN_W);
`ifdef COLSCHED_WALL_PROBE_EN
  localparam logic [1:0] LastProbe = 2'd2;
`else
  localparam logic [1:0] LastProbe = 2'd0;
`endif

  typedef enum logic [2:0] {StIdle, StIssue, StWait, StCapture, StCommit} state_e;

  state_e              state_q;
  logic [IdxW-1:0]     obj_idx_q;
  logic [1:0]          probe_q;
  logic [15:0]         wait_q;
  logic                probe_ok_q;
  logic [9:0]          sh_x [NUM_OBJ];
  logic [9:0]          sh_y [NUM_OBJ];
  logic [9:0]          sh_r [NUM_OBJ];
  logic [NUM_OBJ-1:0]  sh_act;
`ifdef COLSCHED_WALL_PROBE_EN
  logic                land_tmp_q;
  logic                bounce_tmp_q;
  logic                wall_tmp_q;
  logic                wall_eval;
`endif

  // Returns {valid, column} for probe p of an object centred on column x.
  function automatic logic [10:0] probe_col(input logic [9:0] x, input logic [1:0] p);
    logic [10:0] x11;
    logic [10:0] col;
    logic        ok;
    x11 = {1'b0, x};
    case (p)
      2'd1: begin
        col = x11 - 11'd4;
        ok  = (x11 >= 11'd4) && (x11 < ScrLim);
      end
      2'd2: begin
        col = x11 + 11'd4;
        ok  = col < ScrLim;
      end
      default: begin
        col = x11;
        ok  = x11 < ScrLim;
      end
    endcase
    return {ok, col[9:0]};
  endfunction

  function automatic logic bit_at(input logic [COL_W-1:0] d, input logic [10:0] idx);
    return (idx < ColLim) ? d[idx[BitW-1:0]] : 1'b0;
  endfunction

  logic [9:0]       cur_x, cur_y, cur_r;
  logic             last_obj, last_probe, advance, issue_go;
  logic [IdxW-1:0]  nxt_idx;
  logic [10:0]      start_pc, same_pc, nxt_pc, issue_pc;
  logic [COL_W-1:0] cap_data;
  logic [10:0]      y11, r11, yr;
  logic             land_eval, bounce_eval;

  assign cur_x      = sh_x[obj_idx_q];
  assign cur_y      = sh_y[obj_idx_q];
  assign cur_r      = sh_r[obj_idx_q];
  assign last_obj   = obj_idx_q == IdxW'(NUM_OBJ - 1);
  assign last_probe = probe_q == LastProbe;
  assign nxt_idx    = last_obj ? '0 : obj_idx_q + IdxW'(1);
  assign start_pc   = probe_col(obj_x[9:0], 2'd0);
  assign same_pc    = probe_col(cur_x, probe_q + 2'd1);
  assign nxt_pc     = probe_col(sh_x[nxt_idx], 2'd0);

  // Commit is merged into the last probe's capture edge; inactive objects use StCommit.
  assign advance  = (state_q == StCommit) || ((state_q == StCapture) && last_probe);
  assign issue_go = ((state_q == StIdle) && frame_start && obj_active[0]) ||
                    (advance && !last_obj && sh_act[nxt_idx]) ||
                    ((state_q == StCapture) && !last_probe);
  assign issue_pc = (state_q == StIdle) ? start_pc : (advance ? nxt_pc : same_pc);

  // Skipped (out-of-screen) probes read as an empty column.
  assign cap_data    = probe_ok_q ? col_data : '0;
  assign y11         = {1'b0, cur_y};
  assign r11         = {1'b0, cur_r};
  assign yr          = y11 + r11;
  assign land_eval   = (yr >= ColLim) || bit_at(cap_data, yr);
  assign bounce_eval = !land_eval && (y11 >= r11) && bit_at(cap_data, y11 - r11);
`ifdef COLSCHED_WALL_PROBE_EN
  assign wall_eval   = bit_at(cap_data, y11);
`endif

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= StIdle;
      obj_idx_q  <= '0;
      probe_q    <= '0;
      wait_q     <= '0;
      probe_ok_q <= 1'b0;
      col_rd     <= 1'b0;
      col_addr   <= '0;
      landed     <= '0;
      bounce     <= '0;
      impact     <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      sh_act     <= '0;
      for (int i = 0; i < NUM_OBJ; i++) begin
        sh_x[i] <= '0;
        sh_y[i] <= '0;
        sh_r[i] <= '0;
      end
`ifdef COLSCHED_WALL_PROBE_EN
      land_tmp_q   <= 1'b0;
      bounce_tmp_q <= 1'b0;
      wall_tmp_q   <= 1'b0;
`endif
    end else begin
      done     <= 1'b0;
      col_rd   <= 1'b0;
      col_addr <= '0;
      case (state_q)
        StIdle: begin
          if (frame_start) begin
            for (int i = 0; i < NUM_OBJ; i++) begin
              sh_x[i] <= obj_x[10*i +: 10];
              sh_y[i] <= obj_y[10*i +: 10];
              sh_r[i] <= obj_r[10*i +: 10];
            end
            sh_act    <= obj_active;
            obj_idx_q <= '0;
            probe_q   <= '0;
            busy      <= 1'b1;
            state_q   <= obj_active[0] ? StIssue : StCommit;
          end
        end
        StIssue: begin
          wait_q  <= '0;
          state_q <= (RD_LAT == 1) ? StCapture : StWait;
        end
        StWait: begin
          if (wait_q == 16'(RD_LAT - 2)) state_q <= StCapture;
          wait_q <= wait_q + 16'd1;
        end
        StCapture: begin
          if (last_probe) begin
`ifdef COLSCHED_WALL_PROBE_EN
            landed[obj_idx_q] <= land_tmp_q;
            bounce[obj_idx_q] <= bounce_tmp_q;
            impact[obj_idx_q] <= wall_tmp_q | wall_eval;
`else
            landed[obj_idx_q] <= land_eval;
            bounce[obj_idx_q] <= bounce_eval;
            impact[obj_idx_q] <= 1'b0;
`endif
          end else begin
`ifdef COLSCHED_WALL_PROBE_EN
            if (probe_q == 2'd0) begin
              land_tmp_q   <= land_eval;
              bounce_tmp_q <= bounce_eval;
              wall_tmp_q   <= 1'b0;
            end else begin
              wall_tmp_q <= wall_eval;
            end
`endif
            probe_q <= probe_q + 2'd1;
            state_q <= StIssue;
          end
        end
        StCommit: begin
          landed[obj_idx_q] <= 1'b0;
          bounce[obj_idx_q] <= 1'b0;
          impact[obj_idx_q] <= 1'b0;
        end
        default: state_q <= StIdle;
      endcase

      if (advance) begin
        probe_q <= '0;
        if (last_obj) begin
          state_q   <= StIdle;
          obj_idx_q <= '0;
          busy      <= 1'b0;
          done      <= 1'b1;
        end else begin
          obj_idx_q <= nxt_idx;
          state_q   <= sh_act[nxt_idx] ? StIssue : StCommit;
        end
      end

      // An invalid probe still occupies its ISSUE slot, just without a strobe.
      if (issue_go) begin
        col_rd     <= issue_pc[10];
        col_addr   <= issue_pc[10] ? issue_pc[9:0] : 10'd0;
        probe_ok_q <= issue_pc[10];
      end
    end
  end

endmodule
